key_debouncer: RTL and testbench
================================

# key_debouncer

Conditions one raw push-button for the Frogger input path. The block takes an active-low DE1 `KEY` line and synchronizes it to `clk`. It filters contact bounce with a counter-qualified state machine and drives a clean active-high level `w`. That level is the direct upstream input of the press-edge detector, which turns `w` into single-cycle move pulses. One instance sits on each direction key.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized samples needed to accept a level change. Legal range is 1 to 2^CNT_W. Board builds override it; 50 MHz × 10 ms gives 500000.
- `CNT_W`, default 20: width of the debounce counter. It must hold DEBOUNCE_CYCLES-1.
- `clk`  input  1  system clock. All state changes on its rising edge.
- `reset`  input  1  asynchronous, active-low reset. 0 forces all state to reset values immediately; 1 is normal operation.
- `key`  input  1  raw, asynchronous button. 0 = pressed; idle level is 1.
- `w`  output  1  debounced, active-high press level. Registered. Feeds the edge detector's `w`.
- `busy`  output  1  registered. 1 while a level change is being qualified.

## Operation
- Input conditioning:
  - `key` is inverted to `raw` = ~key.
  - `raw` passes through a 2-flop synchronizer `s1`→`s2`. Only `s2` is used downstream.
- FSM states and outputs:
  - RELEASED: w=0, busy=0
  - PRESS_WAIT: w=0, busy=1
  - PRESSED: w=1, busy=0
  - RELEASE_WAIT: w=1, busy=1
- Transitions, evaluated on each rising edge:
  - RELEASED: if `s2`=1, go to PRESS_WAIT and set cnt=0. Otherwise stay.
  - PRESS_WAIT, `s2`=0: go to RELEASED. This is a bounce abort; cnt is don't-care.
  - PRESS_WAIT, `s2`=1 and cnt==DEBOUNCE_CYCLES-1: go to PRESSED.
  - PRESS_WAIT, `s2`=1 otherwise: cnt increments by 1.
  - PRESSED: if `s2`=0, go to RELEASE_WAIT and set cnt=0. Otherwise stay.
  - RELEASE_WAIT, `s2`=1: go to PRESSED. This is a bounce abort.
  - RELEASE_WAIT, `s2`=0 and cnt==DEBOUNCE_CYCLES-1: go to RELEASED.
  - RELEASE_WAIT, `s2`=0 otherwise: cnt increments by 1.
- `w` and `busy` are flops loaded with the next-state decode. They change on the same edge as the state and never glitch.
- Counter rules:
  - The counter is unsigned and CNT_W bits wide.
  - It never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.
  - It is held when the FSM is in RELEASED or PRESSED.
- Reset:
  - Asserting `reset`=0 at any time, including mid-qualification, immediately clears s1, s2, cnt and w to 0, busy to 0, and the state to RELEASED. It does not wait for a clock edge.
  - Deassertion is treated as synchronous by the surrounding design.
  - If `key` is already low at reset release, the normal press path applies.
- Bounce shorter than the qualification window produces no change on `w`. A partial qualification leaves no residue because cnt restarts at 0 on every new entry to a WAIT state.

## Timing
- Press latency: `key` goes low before edge E1 and stays low.
  - E1: s1 captures the press. E2: s2 captures it. E3: state enters PRESS_WAIT.
  - w=1 after edge E(DEBOUNCE_CYCLES+3), which is 7 edges at the default.
- Release latency is symmetric: `w` falls DEBOUNCE_CYCLES+3 edges after `key` rises.
- `busy` is high for exactly DEBOUNCE_CYCLES cycles on a clean transition, from after E3 through E(N+2).
- The minimum stable low or high time on `key` guaranteed to be accepted is DEBOUNCE_CYCLES+1 clock periods.
- A pulse on `key` of at most DEBOUNCE_CYCLES-1 periods is always rejected.
- Throughput: at most one `w` transition per DEBOUNCE_CYCLES+1 cycles.
- DEBOUNCE_CYCLES=1 is legal: PRESS_WAIT lasts one cycle and latency is 4 edges.

## Test plan
All tests use DEBOUNCE_CYCLES=4.
- Reset: from an arbitrary state, drive `reset`=0 between clock edges. Then w=0 and busy=0 before the next edge. Hold `key`=1 and release reset; w stays 0 for 20 cycles.
- Clean press: `key` 1→0 held 20 cycles. Then w=0 through edge 6, w=1 after edge 7, busy=1 after edges 3–6 only.
- Press bounce: `key` low for 3 cycles, then high. Then busy rises and returns to 0, w stays 0 throughout, and the state returns to RELEASED. A following clean 20-cycle press still gives w=1 after its 7th edge.
- Clean release: from PRESSED, `key` 0→1 held. Then w=1 through edge 6 and w=0 after edge 7.
- Release bounce: from PRESSED, `key` high for 2 cycles, then low. Then w stays 1 and busy pulses.
- Reset while pressed: in PRESSED, drive `reset`=0 with `key` still 0. Then w=0 immediately. Release reset; w=1 again after the 7th edge following release.

Source files
------------

// File: rtl/key_debouncer.sv
// Push-button conditioner: synchronizes an active-low key and
// debounces it into a clean active-high press level.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic w,
  output logic busy
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  // Last count of a qualification window.
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             raw;
  logic             s1_q;
  logic             s2_q;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             w_q;
  logic             busy_q;

  assign raw  = ~key;
  assign w    = w_q;
  assign busy = busy_q;

  // Two-flop synchronizer on the inverted key.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  // Debounce FSM; w and busy load the decode of the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      w_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        RELEASED: begin
          if (s2_q) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        PRESS_WAIT: begin
          if (!s2_q) begin
            state_q <= RELEASED;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= PRESSED;
            w_q     <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!s2_q) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RELEASE_WAIT: begin
          if (s2_q) begin
            state_q <= PRESSED;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= RELEASED;
            w_q     <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= RELEASED;
          w_q     <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench for key_debouncer at DEBOUNCE_CYCLES=4.
// Expected w/busy are queued per driven cycle and popped after each edge.
module tb_key_debouncer;

  localparam int N = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic key   = 1'b1;
  logic w;
  logic busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic w;
    logic busy;
  } exp_t;

  exp_t  sb[$];
  string tags[$];
  exp_t  mon_e;
  string mon_t;

  always #5 clk = ~clk;

  key_debouncer #(
    .DEBOUNCE_CYCLES(N),
    .CNT_W(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key(key),
    .w(w),
    .busy(busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Monitor: compare DUT outputs just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        mon_t = tags.pop_front();
        check({mon_t, ".w"}, 32'(w), 32'(mon_e.w));
        check({mon_t, ".busy"}, 32'(busy), 32'(mon_e.busy));
      end
    end
  end

  // Drive key before the next edge and queue what follows it.
  task automatic step(input string tag, input logic k,
                      input logic ew, input logic eb);
    exp_t e;
    e.w    = ew;
    e.busy = eb;
    key = k;
    sb.push_back(e);
    tags.push_back(tag);
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input string tag, input int n,
                      input logic k, input logic ew,
                      input logic eb);
    for (int i = 1; i <= n; i++)
      step($sformatf("%s[%0d]", tag, i), k, ew, eb);
  endtask

  // Clean press: w rises after edge N+3, busy after edges 3..N+2.
  task automatic press(input string tag);
    for (int i = 1; i <= 20; i++)
      step($sformatf("%s[%0d]", tag, i), 1'b0,
           i >= N + 3, i >= 3 && i <= N + 2);
  endtask

  task automatic release_key(input string tag);
    for (int i = 1; i <= 20; i++)
      step($sformatf("%s[%0d]", tag, i), 1'b1,
           i < N + 3, i >= 3 && i <= N + 2);
  endtask

  initial begin
    reset = 1'b0;
    key   = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_w", 32'(w), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    hold("idle", 20, 1'b1, 1'b0, 1'b0);

    press("press");
    release_key("release");

    // Three-cycle press bounce: counter reaches 2, then aborts.
    step("pb[1]", 1'b0, 1'b0, 1'b0);
    step("pb[2]", 1'b0, 1'b0, 1'b0);
    step("pb[3]", 1'b0, 1'b0, 1'b1);
    step("pb[4]", 1'b1, 1'b0, 1'b1);
    step("pb[5]", 1'b1, 1'b0, 1'b1);
    hold("pb_idle", 10, 1'b1, 1'b0, 1'b0);
    press("press2");

    // Two-cycle release bounce: w must hold high.
    step("rb[1]", 1'b1, 1'b1, 1'b0);
    step("rb[2]", 1'b1, 1'b1, 1'b0);
    step("rb[3]", 1'b0, 1'b1, 1'b1);
    step("rb[4]", 1'b0, 1'b1, 1'b1);
    step("rb[5]", 1'b0, 1'b1, 1'b0);
    hold("rb_hold", 10, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a release qualification.
    step("rq[1]", 1'b1, 1'b1, 1'b0);
    step("rq[2]", 1'b1, 1'b1, 1'b0);
    step("rq[3]", 1'b1, 1'b1, 1'b1);
    step("rq[4]", 1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    #1;
    check("rq_rst_w", 32'(w), 32'd0);
    check("rq_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    hold("rq_idle", 20, 1'b1, 1'b0, 1'b0);

    // Reset while pressed with key still held low.
    press("press3");
    key   = 1'b0;
    reset = 1'b0;
    #1;
    check("pr_rst_w", 32'(w), 32'd0);
    check("pr_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #2;
    check("pr_rst_hold_w", 32'(w), 32'd0);
    reset = 1'b1;
    press("press_after_rst");

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
